// File: rtl/cache_burst_addr_encoder.sv
// cache_burst_addr_encoder: expands one block request into a critical-word-first burst of word addresses
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   req_valid_i/req_ready_o         block request handshake (ready only while idle)
//   req_tag_i/req_set_index_i       block location
//   req_start_word_i                first word of the burst
//   addr_valid_o/addr_ready_i       beat handshake
//   addr_o, addr_word_index_o       word-aligned byte address and word index of the beat
//   addr_last_o                     final beat of the burst
//   done_o                          one-cycle pulse after the final beat
//   busy_o                          burst in progress
module cache_burst_addr_encoder #(
  parameter int WORD_CAPACITY   = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int WAY_COUNT       = 1,
  parameter int ADDR_BITS       = 32,
  parameter int WORD_BITS       = 32,
  localparam int SET_COUNT = WORD_CAPACITY / WORDS_PER_BLOCK / WAY_COUNT,
  localparam int SB = $clog2(SET_COUNT),
  localparam int WB = $clog2(WORDS_PER_BLOCK),
  localparam int BB = $clog2(WORD_BITS / 8),
  localparam int TB = ADDR_BITS - SB - WB - BB
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [TB-1:0]        req_tag_i,
  input  logic [SB-1:0]        req_set_index_i,
  input  logic [WB-1:0]        req_start_word_i,
  output logic                 addr_valid_o,
  input  logic                 addr_ready_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [WB-1:0]        addr_word_index_o,
  output logic                 addr_last_o,
  output logic                 done_o,
  output logic                 busy_o
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [TB-1:0] tag_q;
  logic [SB-1:0] set_q;
  logic [WB-1:0] word_q;
  logic [WB-1:0] beat_q;
  logic          done_q;
  logic          last;
  logic          accept;
  logic          beat_hs;
  assign last    = beat_q == WB'(WORDS_PER_BLOCK - 1);
  assign accept  = req_valid_i && req_ready_o;
  assign beat_hs = addr_valid_o && addr_ready_i;
  always_ff @(posedge clk_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE) ? (req_valid_i ? BURST : IDLE)
                                : ((addr_ready_i && last) ? IDLE : BURST);
  always_comb begin
    req_ready_o  = state_q == IDLE;
    addr_valid_o = state_q == BURST;
    busy_o       = state_q == BURST;
    addr_last_o  = (state_q == BURST) && last;
    done_o       = done_q;
  end
  // word counter is exactly WB bits wide, so the increment wraps modulo WORDS_PER_BLOCK
  always_ff @(posedge clk_i)
    if (rst_i) begin
      tag_q  <= '0;
      set_q  <= '0;
      word_q <= '0;
      beat_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= beat_hs && last;
      if (accept) begin
        tag_q  <= req_tag_i;
        set_q  <= req_set_index_i;
        word_q <= req_start_word_i;
        beat_q <= '0;
      end else if (beat_hs) begin
        word_q <= word_q + 1'b1;
        beat_q <= beat_q + 1'b1;
      end
    end
  // shift instead of a zero-replication so WORD_BITS=8 (BB=0) still elaborates
  assign addr_o            = ADDR_BITS'({tag_q, set_q, word_q}) << BB;
  assign addr_word_index_o = word_q;
endmodule

// File: tb/tb_cache_burst_addr_encoder.sv
// tb_cache_burst_addr_encoder: scoreboard bench for the burst address encoder at default parameters
module tb_cache_burst_addr_encoder;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [26:0] req_tag_i = '0;
  logic [0:0]  req_set_index_i = '0;
  logic [1:0]  req_start_word_i = '0;
  logic        addr_valid_o;
  logic        addr_ready_i = 1'b0;
  logic [31:0] addr_o;
  logic [1:0]  addr_word_index_o;
  logic        addr_last_o;
  logic        done_o;
  logic        busy_o;
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  idx;
    logic        last;
  } beat_t;
  beat_t sb[$];
  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int done_count = 0;
  cache_burst_addr_encoder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_tag_i(req_tag_i), .req_set_index_i(req_set_index_i), .req_start_word_i(req_start_word_i),
    .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
    .addr_o(addr_o), .addr_word_index_o(addr_word_index_o), .addr_last_o(addr_last_o),
    .done_o(done_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (!rst_i && addr_valid_o && addr_ready_i) begin
      beat_t e;
      hs_count++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_beat: got addr=%h idx=%0d last=%0b, expected no beat", addr_o, addr_word_index_o, addr_last_o);
      end else begin
        e = sb.pop_front();
        if ({addr_o, addr_word_index_o, addr_last_o} !== {e.addr, e.idx, e.last}) begin
          bad++;
          $display("FAIL sb_beat: got addr=%h idx=%0d last=%0b, expected addr=%h idx=%0d last=%0b",
                   addr_o, addr_word_index_o, addr_last_o, e.addr, e.idx, e.last);
        end
      end
    end
    if (done_o) done_count++;
  end
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic push_burst(input logic [26:0] tag, input logic [0:0] set, input logic [1:0] start);
    logic [1:0] w;
    w = start;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{addr: {tag, set, w, 2'b00}, idx: w, last: i == 3});
      w = w + 2'd1;
    end
  endtask
  task automatic request(input logic [26:0] tag, input logic [0:0] set, input logic [1:0] start);
    req_tag_i = tag;
    req_set_index_i = set;
    req_start_word_i = start;
    req_valid_i = 1'b1;
    push_burst(tag, set, start);
    tick;
    req_valid_i = 1'b0;
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    tick;
    tick;
    total++;
    if ({addr_valid_o, done_o, busy_o, addr_last_o, addr_o, addr_word_index_o} !== 38'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b d=%0b b=%0b l=%0b addr=%h idx=%0d, expected all zero",
               addr_valid_o, done_o, busy_o, addr_last_o, addr_o, addr_word_index_o);
    end
    rst_i = 1'b0;
    tick;
    total++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got ready=%0b busy=%0b, expected 1 0", req_ready_o, busy_o);
    end
  endtask
  task automatic test_basic;
    logic [31:0] exp_a [4] = '{32'h15790, 32'h15794, 32'h15798, 32'h1579C};
    addr_ready_i = 1'b1;
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_ready_idle: got %0b expected 1", req_ready_o);
    end
    request(27'hABC, 1'b1, 2'd0);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (addr_valid_o !== 1'b1 || busy_o !== 1'b1 || req_ready_o !== 1'b0 || addr_o !== exp_a[c] || addr_last_o !== (c == 3)) begin
        bad++;
        $display("FAIL basic_beat%0d: got v=%0b b=%0b r=%0b addr=%h last=%0b, expected 1 1 0 %h %0b",
                 c, addr_valid_o, busy_o, req_ready_o, addr_o, addr_last_o, exp_a[c], c == 3);
      end
      tick;
    end
    total++;
    if (done_o !== 1'b1 || req_ready_o !== 1'b1 || busy_o !== 1'b0 || addr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: got d=%0b r=%0b b=%0b v=%0b, expected 1 1 0 0", done_o, req_ready_o, busy_o, addr_valid_o);
    end
    tick;
    total++;
    if (done_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_width: got %0b expected 0", done_o);
    end
  endtask
  task automatic test_wrap;
    logic [1:0] exp_i [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] exp_a [4] = '{32'h15798, 32'h1579C, 32'h15790, 32'h15794};
    addr_ready_i = 1'b1;
    request(27'hABC, 1'b1, 2'd2);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (addr_word_index_o !== exp_i[c] || addr_o !== exp_a[c]) begin
        bad++;
        $display("FAIL wrap_beat%0d: got idx=%0d addr=%h, expected idx=%0d addr=%h", c, addr_word_index_o, addr_o, exp_i[c], exp_a[c]);
      end
      tick;
    end
    total++;
    if (done_o !== 1'b1) begin
      bad++;
      $display("FAIL wrap_done: got %0b expected 1", done_o);
    end
    tick;
  endtask
  task automatic test_backpressure;
    int hs0;
    hs0 = hs_count;
    addr_ready_i = 1'b1;
    request(27'hABC, 1'b1, 2'd0);
    tick;
    tick;
    addr_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      total++;
      if (addr_valid_o !== 1'b1 || addr_o !== 32'h15798 || addr_word_index_o !== 2'd2 || addr_last_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%0b addr=%h idx=%0d last=%0b, expected 1 00015798 2 0",
                 c, addr_valid_o, addr_o, addr_word_index_o, addr_last_o);
      end
    end
    addr_ready_i = 1'b1;
    tick;
    tick;
    total++;
    if (done_o !== 1'b1 || hs_count - hs0 !== 4) begin
      bad++;
      $display("FAIL bp_done: got done=%0b handshakes=%0d, expected 1 4", done_o, hs_count - hs0);
    end
    tick;
  endtask
  task automatic test_back_to_back;
    addr_ready_i = 1'b1;
    req_tag_i = 27'h111;
    req_set_index_i = 1'b0;
    req_start_word_i = 2'd1;
    req_valid_i = 1'b1;
    push_burst(27'h111, 1'b0, 2'd1);
    tick;
    req_tag_i = 27'h222;
    req_set_index_i = 1'b1;
    req_start_word_i = 2'd3;
    push_burst(27'h222, 1'b1, 2'd3);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (req_ready_o !== 1'b0 || addr_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL b2b_busy%0d: got ready=%0b valid=%0b, expected 0 1", c, req_ready_o, addr_valid_o);
      end
      tick;
    end
    total++;
    if (done_o !== 1'b1 || req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done: got done=%0b ready=%0b, expected 1 1", done_o, req_ready_o);
    end
    tick;
    req_valid_i = 1'b0;
    total++;
    if (addr_valid_o !== 1'b1 || addr_o !== 32'h0000445C || done_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_first: got v=%0b addr=%h done=%0b, expected 1 0000445c 0", addr_valid_o, addr_o, done_o);
    end
    for (int c = 0; c < 4; c++) tick;
    total++;
    if (done_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_done: got %0b expected 1", done_o);
    end
    tick;
  endtask
  task automatic test_reset_mid;
    int d0;
    int hs0;
    addr_ready_i = 1'b1;
    request(27'h0F0, 1'b0, 2'd1);
    tick;
    d0 = done_count;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    sb.delete();
    total++;
    if (addr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_abort: got v=%0b b=%0b d=%0b r=%0b, expected 0 0 0 1", addr_valid_o, busy_o, done_o, req_ready_o);
    end
    for (int c = 0; c < 4; c++) tick;
    total++;
    if (done_count !== d0) begin
      bad++;
      $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_count - d0);
    end
    hs0 = hs_count;
    request(27'h0F0, 1'b1, 2'd0);
    for (int c = 0; c < 4; c++) tick;
    total++;
    if (done_o !== 1'b1 || hs_count - hs0 !== 4) begin
      bad++;
      $display("FAIL rstmid_next_burst: got done=%0b handshakes=%0d, expected 1 4", done_o, hs_count - hs0);
    end
    tick;
  endtask
  task automatic test_top_addr;
    addr_ready_i = 1'b1;
    request(27'h7FFFFFF, 1'b0, 2'd3);
    total++;
    if (addr_o !== 32'hFFFFFFEC || addr_word_index_o !== 2'd3) begin
      bad++;
      $display("FAIL top_first: got addr=%h idx=%0d, expected ffffffec 3", addr_o, addr_word_index_o);
    end
    tick;
    total++;
    if (addr_o !== 32'hFFFFFFE0 || addr_word_index_o !== 2'd0) begin
      bad++;
      $display("FAIL top_wrap: got addr=%h idx=%0d, expected ffffffe0 0", addr_o, addr_word_index_o);
    end
    for (int c = 0; c < 3; c++) tick;
    total++;
    if (done_o !== 1'b1) begin
      bad++;
      $display("FAIL top_done: got %0b expected 1", done_o);
    end
    tick;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_top_addr;
    tick;
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending beats expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_burst_addr_encoder.md
CACHE_BURST_ADDR_ENCODER -- requirements
Module: cache_burst_addr_encoder

Interface
REQ-001 SHALL have parameter WORD_CAPACITY, default 8, meaning cache capacity in words.
REQ-002 SHALL have parameter WORDS_PER_BLOCK, default 4, meaning words per block; power of two, at least 2.
REQ-003 SHALL have parameter WAY_COUNT, default 1, meaning associativity.
REQ-004 SHALL have parameter ADDR_BITS, default 32, meaning byte-address width.
REQ-005 SHALL have parameter WORD_BITS, default 32, meaning word width in bits.
REQ-006 SHALL derive widths as follows: SET_COUNT = WORD_CAPACITY/WORDS_PER_BLOCK/WAY_COUNT (at least 2); SB = clog2(SET_COUNT); WB = clog2(WORDS_PER_BLOCK); BB = clog2(WORD_BITS/8); TB = ADDR_BITS-SB-WB-BB.
REQ-007 SHALL have port clk_i, input, 1 bit: sole clock; all logic is on the rising edge.
REQ-008 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port req_valid_i, input, 1 bit: block-burst request valid.
REQ-010 SHALL have port req_ready_o, output, 1 bit: request may be accepted.
REQ-011 SHALL have port req_tag_i, input, TB bits: block tag.
REQ-012 SHALL have port req_set_index_i, input, SB bits: block set index.
REQ-013 SHALL have port req_start_word_i, input, WB bits: first word to emit (critical word first).
REQ-014 SHALL have port addr_valid_o, output, 1 bit: addr_o valid.
REQ-015 SHALL have port addr_ready_i, input, 1 bit: downstream accepts addr_o.
REQ-016 SHALL have port addr_o, output, ADDR_BITS bits: word-aligned byte address.
REQ-017 SHALL have port addr_word_index_o, output, WB bits: word index of the current beat.
REQ-018 SHALL have port addr_last_o, output, 1 bit: current beat is the final beat of the burst.
REQ-019 SHALL have port done_o, output, 1 bit: one-cycle burst-complete pulse.
REQ-020 SHALL have port busy_o, output, 1 bit: burst in progress.

Function
REQ-021 SHALL implement a two-state FSM: IDLE and BURST.
REQ-022 SHALL drive req_ready_o = 1 in IDLE and 0 in BURST, combinationally from the state.
REQ-023 SHALL accept a request when req_valid_i and req_ready_o are both 1. On acceptance it SHALL register tag, set and start word, load the word counter with req_start_word_i, clear the beat counter, and go to BURST.
REQ-024 SHALL drive addr_valid_o = 1 throughout BURST, starting the cycle after acceptance (latency 1), and 0 in IDLE.
REQ-025 SHALL form addr_o = {tag, set, word counter, BB zero bits}, which is the exact inverse of the tag/set/word/byte address split.
REQ-026 SHALL hold addr_o, addr_word_index_o and addr_last_o stable while addr_valid_o=1 and addr_ready_i=0.
REQ-027 SHALL, on each beat handshake (addr_valid_o & addr_ready_i), increment the word counter modulo WORDS_PER_BLOCK (wrapping from WORDS_PER_BLOCK-1 to 0) and increment the beat counter.
REQ-028 SHALL assert addr_last_o when beat counter = WORDS_PER_BLOCK-1; exactly WORDS_PER_BLOCK beats SHALL be emitted per burst, each word index exactly once.
REQ-029 SHALL, on the handshake of the last beat, return to IDLE, and assert done_o for exactly the following cycle, with req_ready_o=1 in that same cycle.
REQ-030 SHALL ignore request inputs while in BURST; changes to them SHALL NOT affect the burst in flight.
REQ-031 SHALL drive busy_o = 1 exactly while in BURST.
REQ-032 SHALL tolerate addr_ready_i held high continuously: one beat per cycle, with no bubbles.

Reset
REQ-033 SHALL, while rst_i=1 at a clock edge, enter IDLE and clear the counters.
REQ-034 SHALL hold reset output values: addr_valid_o=0, done_o=0, busy_o=0, addr_last_o=0, addr_o=0, addr_word_index_o=0; req_ready_o=1 from the first cycle after reset.
REQ-035 SHALL abort an in-flight burst on reset mid-burst, with no done_o pulse; the next burst after reset SHALL start clean.

Verification (defaults: SB=1, WB=2, BB=2, TB=27)
REQ-036 SHALL pass this scenario: tag=0xABC, set=1, start=0, addr_ready_i=1 -> addr_o 0x15790, 0x15794, 0x15798, 0x1579C on consecutive cycles; last on the 4th beat; done_o on the next cycle.
REQ-037 SHALL pass this wrap scenario: tag=0xABC, set=1, start=2 -> 0x15798, 0x1579C, 0x15790, 0x15794; word indices 2, 3, 0, 1.
REQ-038 SHALL pass this backpressure scenario: addr_ready_i low for 3 cycles during beat 2 -> addr_o held at beat-2 value; sequence unchanged; total 4 handshakes.
REQ-039 SHALL pass this scenario: new req_valid_i held high during BURST -> not accepted until the done_o cycle; second burst's first beat appears the cycle after that.
REQ-040 SHALL pass this scenario: rst_i asserted after beat 1 -> next cycle addr_valid_o=0, busy_o=0, done_o never pulses; a subsequent request emits a full 4-beat burst.
REQ-041 SHALL pass this scenario: tag=0x7FFFFFF, set=0, start=3 -> first addr_o 0xFFFFFFEC; the next beat wraps to word index 0, giving addr_o 0xFFFFFFE0.
